// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard frame receiver and scancode decoder
// Emits toggle-flagged key events with press/release and E0-extended qualifiers.
module ps2_key_decoder #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 13000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = (FILTER  > 1) ? $clog2(FILTER + 1)  : 1;
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f, clk_f_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          ext_q, ext_d, rel_q, rel_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [10:0]   key_d;
  logic          err_d;

  // Synchronizers and the glitch filter idle high, matching an idle PS/2 bus.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      clk_f      <= 1'b1;
      clk_f_prev <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= ps2_data;
      dat_s2     <= dat_s1;
      clk_f_prev <= clk_f;
      if (clk_s2 != clk_f) begin
        if (filt_cnt == FW'(FILTER - 1)) begin
          clk_f    <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = clk_f_prev & ~clk_f;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
      tmo_q     <= '0;
      ps2_key   <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      ext_q     <= ext_d;
      rel_q     <= rel_d;
      tmo_q     <= tmo_d;
      ps2_key   <= key_d;
      frame_err <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    key_d     = ps2_key;
    err_d     = 1'b0;
    tmo_d     = (fall || state_q == IDLE) ? '0 : tmo_q + 1'b1;

    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_s2) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d = {dat_s2, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = PARITY;
          else                   bit_cnt_d = bit_cnt_q + 1'b1;
        end
        PARITY: begin
          par_d   = dat_s2;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s2 && (^{shift_q, par_q})) begin
            case (shift_q)
              8'hE0: ext_d = 1'b1;
              8'hF0: rel_d = 1'b1;
              // Keyboard status/ack codes carry no key information.
              8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1: ;
              default: begin
                key_d = {~ps2_key[10], ~rel_q, ext_q, shift_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
              end
            endcase
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - randomized self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 300;
  localparam int HALF    = 15;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  always #5 clk_sys = ~clk_sys;

  ps2_key_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .frame_err (frame_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int err_seen = 0;
  int err_wide = 0;
  logic err_prev = 1'b0;

  logic [10:0] exp_key = '0;
  bit          m_ext = 1'b0;
  bit          m_rel = 1'b0;
  int          exp_err = 0;
  logic [7:0]  discard_codes [7] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1};

  always @(negedge clk_sys) begin
    if (frame_err) begin
      err_seen++;
      if (err_prev) err_wide++;
    end
    err_prev = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: key events derive from the byte stream and prefix rules only.
  task automatic model_frame(input logic [7:0] b, input bit ok);
    bit is_discard;
    is_discard = 1'b0;
    foreach (discard_codes[i]) if (discard_codes[i] == b) is_discard = 1'b1;
    if (!ok) begin
      exp_err++;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (!is_discard) begin
      exp_key = {~exp_key[10], ~m_rel, m_ext, b};
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            output int lat, output logic [10:0] key_at_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_data = ~bad_stop;
    repeat (HALF) @(negedge clk_sys);
    key_at_stop = ps2_key;
    ps2_clk = 1'b0;
    lat = -1;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clk_sys);
      if (lat < 0 && ps2_key !== key_at_stop) lat = i;
    end
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk_sys);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int lat;
    logic [10:0] k_stop;
    logic [10:0] k_before;
    k_before = exp_key;
    send_frame(b, bad_par, bad_stop, lat, k_stop);
    model_frame(b, !bad_par && !bad_stop);
    repeat (3) @(negedge clk_sys);
    chk({tag, "_key"}, ps2_key, exp_key);
    chk({tag, "_errcnt"}, err_seen, exp_err);
    if (exp_key != k_before) begin
      chk({tag, "_prestop"}, k_stop, k_before);
      chk({tag, "_latok"}, (lat >= 1 && lat <= FILTER + 8), 1);
    end
  endtask

  initial begin
    int n;
    int e0;
    int r;
    logic [7:0] b;
    bit bp, bs;

    repeat (5) @(negedge clk_sys);
    chk("rst_key", ps2_key, 11'h000);
    chk("rst_err", frame_err, 1'b0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);

    run_frame("first_1c", 8'h1C, 0, 0);
    chk("first_1c_abs", ps2_key, 11'h61C);

    run_frame("e0", 8'hE0, 0, 0);
    run_frame("f0", 8'hF0, 0, 0);
    run_frame("75", 8'h75, 0, 0);
    chk("75_abs", ps2_key, 11'h175);

    run_frame("badpar", 8'h1C, 1, 0);
    run_frame("after_badpar", 8'h1C, 0, 0);
    chk("after_badpar_abs", ps2_key, 11'h61C);

    e0 = err_seen;
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk_sys);
    chk("glitch_noerr", err_seen, e0);
    run_frame("after_glitch", 8'h4D, 0, 0);

    ps2_bit(1'b1);
    model_frame(8'h00, 0);
    repeat (5) @(negedge clk_sys);
    chk("startbit_err", err_seen, exp_err);

    run_frame("badstop", 8'h33, 0, 1);

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    e0 = err_seen;
    n = HALF;
    while (err_seen == e0 && n < TIMEOUT + 100) begin
      @(negedge clk_sys);
      n++;
    end
    chk("timeout_window", (n >= TIMEOUT && n <= TIMEOUT + 30), 1);
    model_frame(8'h00, 0);
    chk("timeout_errcnt", err_seen, exp_err);
    run_frame("after_timeout", 8'h29, 0, 0);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       b = 8'hE0;
      else if (r < 4)  b = 8'hF0;
      else if (r == 4) b = discard_codes[$urandom_range(0, 6)];
      else             b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 15);
      bp = (r == 0);
      bs = (r == 1);
      run_frame("rand", b, bp, bs);
    end

    run_frame("pre_rst_f0", 8'hF0, 0, 0);
    @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("midrst_key", ps2_key, 11'h000);
    chk("midrst_err", frame_err, 1'b0);
    reset_n = 1'b1;
    exp_key = '0;
    m_ext = 1'b0;
    m_rel = 1'b0;
    repeat (5) @(negedge clk_sys);
    run_frame("post_rst", 8'h1C, 0, 0);
    chk("post_rst_abs", ps2_key, 11'h61C);

    chk("err_single_cycle", err_wide, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
